// File: rtl/branch_cond_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_cond_unit_if : branch request / PC redirect bundle (Rev 1.0)    |
// +------------------------------------------------------------------------+
interface branch_cond_unit_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) ();
  logic              br_req;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] target;
  logic              N;
  logic              Z;
  logic              C;
  logic              V;

  logic              br_busy;
  logic              br_done;
  logic              taken;
  logic              cond_illegal;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_out;
  logic              flush;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  eval_cnt;

  // Control unit / flag logic side.
  modport master (
    output br_req, cond, target, N, Z, C, V,
    input  br_busy, br_done, taken, cond_illegal, pc_load, pc_out, flush,
           taken_cnt, eval_cnt
  );

  modport slave (
    input  br_req, cond, target, N, Z, C, V,
    output br_busy, br_done, taken, cond_illegal, pc_load, pc_out, flush,
           taken_cnt, eval_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_cond_unit : NZCV branch condition evaluation and PC redirect    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module branch_cond_unit #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  branch_cond_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_REDIRECT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       COND_RSVD = 4'hF;

  state_t            state_q, state_d;
  logic [3:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic [3:0]        flags_q;      // {N,Z,C,V} captured at acceptance
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]  eval_cnt_q, eval_cnt_d;

  logic              w_accept;
  logic              w_base;
  logic              w_cond_true;
  logic              w_n, w_z, w_c, w_v;

  assign w_accept = (state_q == S_IDLE) && bus.br_req;
  assign {w_n, w_z, w_c, w_v} = flags_q;

  // Conditions come in complementary pairs: cond[3:1] picks the base test,
  // cond[0] inverts it. Reserved code F would decode as "never" anyway.
  always_comb begin
    w_base = 1'b0;
    unique case (cond_q[3:1])
      3'd0: w_base = w_z;
      3'd1: w_base = w_c;
      3'd2: w_base = w_n;
      3'd3: w_base = w_v;
      3'd4: w_base = w_c & ~w_z;
      3'd5: w_base = ~(w_n ^ w_v);
      3'd6: w_base = ~w_z & ~(w_n ^ w_v);
      3'd7: w_base = 1'b1;
    endcase
    w_cond_true = (cond_q == COND_RSVD) ? 1'b0 : (w_base ^ cond_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      taken_q     <= 1'b0;
      taken_cnt_q <= '0;
      eval_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      taken_q     <= taken_d;
      taken_cnt_q <= taken_cnt_d;
      eval_cnt_q  <= eval_cnt_d;
    end
  end

  // Snapshot of the request; later flag/target changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q   <= 4'h0;
      target_q <= '0;
      flags_q  <= 4'h0;
    end else if (w_accept) begin
      cond_q   <= bus.cond;
      target_q <= bus.target;
      flags_q  <= {bus.N, bus.Z, bus.C, bus.V};
    end
  end

  always_comb begin
    state_d     = state_q;
    taken_d     = taken_q;
    taken_cnt_d = taken_cnt_q;
    eval_cnt_d  = eval_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.br_req) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d = w_cond_true;
        state_d = w_cond_true ? S_REDIRECT : S_DONE;
      end
      S_REDIRECT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (eval_cnt_q != CNT_MAX) begin
          eval_cnt_d = eval_cnt_q + CNT_ONE;
        end
        if (taken_q && (taken_cnt_q != CNT_MAX)) begin
          taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only, so no input reaches them combinationally.
  assign bus.br_busy      = (state_q != S_IDLE);
  assign bus.pc_load      = (state_q == S_REDIRECT);
  assign bus.flush        = (state_q == S_REDIRECT);
  assign bus.pc_out       = (state_q == S_REDIRECT) ? target_q : '0;
  assign bus.br_done      = (state_q == S_DONE);
  assign bus.taken        = (state_q == S_DONE) && taken_q;
  assign bus.cond_illegal = (state_q == S_DONE) && (cond_q == COND_RSVD);
  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.eval_cnt     = eval_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_branch_cond_unit : randomized self-checking bench, Rev 1.0          |
// +------------------------------------------------------------------------+
module tb_branch_cond_unit;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [CNT_W-1:0] mdl_eval_cnt;
  logic [CNT_W-1:0] mdl_taken_cnt;

  branch_cond_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_if ();

  branch_cond_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural meaning of each condition code, straight from the table.
  function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] nzcv);
    bit n, z, cy, v;
    {n, z, cy, v} = nzcv;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs(input string ph, input bit busy, input bit pcl,
                               input logic [ADDR_W-1:0] pco, input bit done,
                               input bit tk, input bit ill);
    check({ph, ".br_busy"},      32'(bus_if.br_busy),      32'(busy));
    check({ph, ".pc_load"},      32'(bus_if.pc_load),      32'(pcl));
    check({ph, ".flush"},        32'(bus_if.flush),        32'(pcl));
    check({ph, ".pc_out"},       32'(bus_if.pc_out),       32'(pco));
    check({ph, ".br_done"},      32'(bus_if.br_done),      32'(done));
    check({ph, ".taken"},        32'(bus_if.taken),        32'(tk));
    check({ph, ".cond_illegal"}, 32'(bus_if.cond_illegal), 32'(ill));
    check({ph, ".eval_cnt"},     32'(bus_if.eval_cnt),     32'(mdl_eval_cnt));
    check({ph, ".taken_cnt"},    32'(bus_if.taken_cnt),    32'(mdl_taken_cnt));
  endtask

  // One branch, walked cycle by cycle. Inputs are scrambled once captured;
  // with hold=1 br_req stays high while busy and must be ignored.
  task automatic run_branch(input logic [3:0] c, input logic [3:0] nzcv,
                            input logic [ADDR_W-1:0] tgt, input bit hold);
    bit exp_t;
    int n_stages;
    logic [3:0] rnd;
    @(negedge clk);
    bus_if.br_req = 1'b1;
    bus_if.cond   = c;
    {bus_if.N, bus_if.Z, bus_if.C, bus_if.V} = nzcv;
    bus_if.target = tgt;
    exp_t    = ref_taken(c, nzcv);
    n_stages = exp_t ? 3 : 2;
    for (int s = 0; s < n_stages; s++) begin
      @(negedge clk);
      bus_if.br_req = hold;
      rnd = 4'($urandom);
      {bus_if.N, bus_if.Z, bus_if.C, bus_if.V} = rnd;
      bus_if.cond   = 4'($urandom);
      bus_if.target = ADDR_W'($urandom);
      if (s == n_stages - 1) begin
        check_outputs("done", 1'b1, 1'b0, '0, 1'b1, exp_t, c == 4'hF);
        if (mdl_eval_cnt != {CNT_W{1'b1}}) mdl_eval_cnt++;
        if (exp_t && (mdl_taken_cnt != {CNT_W{1'b1}})) mdl_taken_cnt++;
      end else if (s == 1) begin
        check_outputs("redirect", 1'b1, 1'b1, tgt, 1'b0, 1'b0, 1'b0);
      end else begin
        check_outputs("eval", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    bus_if.br_req = 1'b0;
    check_outputs("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    mdl_eval_cnt  = '0;
    mdl_taken_cnt = '0;
    rst           = 1'b1;
    bus_if.br_req = 1'b0;
    bus_if.cond   = 4'h0;
    bus_if.target = '0;
    {bus_if.N, bus_if.Z, bus_if.C, bus_if.V} = 4'h0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check_outputs("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_outputs("post_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // EQ taken / not taken
    run_branch(4'h0, 4'b0100, 12'h3A5, 1'b0);
    check("eq_taken.taken_cnt", 32'(bus_if.taken_cnt), 32'd1);
    check("eq_taken.eval_cnt",  32'(bus_if.eval_cnt),  32'd1);
    run_branch(4'h0, 4'b0000, 12'h123, 1'b0);
    check("eq_not.eval_cnt",    32'(bus_if.eval_cnt),  32'd2);

    // Signed / unsigned corner cases
    run_branch(4'hB, 4'b1000, 12'h0F0, 1'b0);
    run_branch(4'hC, 4'b1001, 12'h0F1, 1'b0);
    run_branch(4'h8, 4'b0110, 12'h0F2, 1'b0);

    // In-flight flag change and held request, then reserved condition
    run_branch(4'h0, 4'b0100, 12'hABC, 1'b1);
    run_branch(4'hF, 4'b1111, 12'hFFF, 1'b0);

    // Full condition x flag sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        run_branch(4'(c), 4'(f), ADDR_W'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    // Reset while redirecting aborts the branch
    @(negedge clk);
    bus_if.br_req = 1'b1;
    bus_if.cond   = 4'hE;
    bus_if.target = 12'h5A5;
    @(negedge clk);
    bus_if.br_req = 1'b0;
    check_outputs("abort_eval", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs("abort_redirect", 1'b1, 1'b1, 12'h5A5, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    mdl_eval_cnt  = '0;
    mdl_taken_cnt = '0;
    @(negedge clk);
    check_outputs("abort_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs("abort_after", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Saturation of the taken counter
    force dut.taken_cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.taken_cnt_q;
    mdl_taken_cnt = {CNT_W{1'b1}};
    run_branch(4'hE, 4'($urandom), 12'h777, 1'b0);
    check("sat.taken_cnt", 32'(bus_if.taken_cnt), 32'hFFFF);
    check("sat.eval_cnt",  32'(bus_if.eval_cnt),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
